// File: rtl/cpu_controller_if.sv
// cpu_controller_if: memory, register-file and ALU connections of cpu_controller
// master = controller side, slave = memory/register-file/ALU side.
// mem_*: address, write data/strobe out, 1-cycle-latency read data in.
// rf_*: two combinational read ports (a = Rdest, b = Rsrc) and one write port.
// alu_*: operands/opcode out, result and {C,L,F,Z,N} flags in.
// pc_out/psr_out: debug view of PC and PSR.
interface cpu_controller_if #(parameter int ADDR_W = 16);
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0] mem_rdata;
    logic [15:0] mem_wdata;
    logic mem_we;
    logic [3:0] rf_raddr_a;
    logic [3:0] rf_raddr_b;
    logic [15:0] rf_rdata_a;
    logic [15:0] rf_rdata_b;
    logic rf_we;
    logic [3:0] rf_waddr;
    logic [15:0] rf_wdata;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [7:0] alu_op;
    logic [15:0] alu_c;
    logic [4:0] alu_flags;
    logic [ADDR_W-1:0] pc_out;
    logic [4:0] psr_out;
    modport master (
        output mem_addr, mem_wdata, mem_we, rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wdata,
               alu_a, alu_b, alu_op, pc_out, psr_out,
        input  mem_rdata, rf_rdata_a, rf_rdata_b, alu_c, alu_flags
    );
    modport slave (
        input  mem_addr, mem_wdata, mem_we, rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wdata,
               alu_a, alu_b, alu_op, pc_out, psr_out,
        output mem_rdata, rf_rdata_a, rf_rdata_b, alu_c, alu_flags
    );
endinterface

// File: rtl/cpu_controller.sv
// cpu_controller: multi-cycle fetch/decode/execute sequencer driving an external ALU, register file and memory
// clk: rising-edge clock; rst_n: asynchronous active-low reset.
// bus (cpu_controller_if.master): memory, register-file and ALU ports plus pc_out/psr_out debug.
module cpu_controller #(
    parameter int ADDR_W = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic clk,
    input logic rst_n,
    cpu_controller_if.master bus
);
    typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_LOAD} state_t;
    state_t state, state_n;
    logic [ADDR_W-1:0] pc, pc_n, pc_inc, disp, jump_target;
    logic [15:0] ir;
    logic [4:0] psr;
    logic [3:0] hi, lo;
    logic [15:0] cond_vec;
    logic rtype, lsh, lshi, imm, alu_cls, is_cmp, flag_op;
    logic load, stor, bcond, jcond, jal, taken, exec;
    logic c, l, f, z, n;
    assign hi = ir[15:12];
    assign lo = ir[7:4];
    assign {c, l, f, z, n} = psr;
    always_comb begin
        rtype = hi == 4'h0;
        lsh = hi == 4'h8 && lo == 4'h4;
        lshi = hi == 4'h8 && lo[3:1] == 3'b000;
        imm = hi inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD, 4'hF};
        alu_cls = rtype || lsh || lshi || imm;
        is_cmp = rtype ? lo == 4'hB : hi == 4'hB;
        // ADD/SUB/CMP/AND share the same code in the R-type minor field and the immediate major field
        flag_op = (rtype ? lo : hi) inside {4'h1, 4'h5, 4'h9, 4'hB};
        load = hi == 4'h4 && lo == 4'h0;
        stor = hi == 4'h4 && lo == 4'h4;
        jal = hi == 4'h4 && lo == 4'h8;
        jcond = hi == 4'h4 && lo == 4'hC;
        bcond = hi == 4'hC;
        exec = state == S_EXEC;
        // Indexed by the condition code; conditions look at the stored PSR only
        cond_vec = {1'b0, 1'b1, n | z, !n & !z, l | z, !l & !z, !f, f, !n, n, !l, l, !c, c, !z, z};
        taken = cond_vec[ir[11:8]];
        pc_inc = pc + 1'b1;
        disp = {{(ADDR_W-8){ir[7]}}, ir[7:0]};
        jump_target = bus.rf_rdata_b[ADDR_W-1:0];
        bus.rf_raddr_a = ir[11:8];
        bus.rf_raddr_b = ir[3:0];
        bus.rf_waddr = ir[11:8];
        bus.alu_a = bus.rf_rdata_a;
        bus.alu_b = (rtype || lsh) ? bus.rf_rdata_b : lshi ? {12'h000, ir[3:0]} : {8'h00, ir[7:0]};
        bus.alu_op = {hi, lo};
        bus.mem_addr = (exec && (load || stor)) ? jump_target : pc;
        bus.mem_wdata = bus.rf_rdata_a;
        bus.mem_we = exec && stor;
        bus.rf_we = (exec && ((alu_cls && !is_cmp) || jal)) || state == S_LOAD;
        bus.rf_wdata = state == S_LOAD ? bus.mem_rdata : jal ? 16'(pc_inc) : bus.alu_c;
        bus.pc_out = pc;
        bus.psr_out = psr;
        state_n = state == S_FETCH ? S_DECODE : state == S_DECODE ? S_EXEC : (exec && load) ? S_LOAD : S_FETCH;
        pc_n = state == S_LOAD ? pc_inc :
               (!exec || load) ? pc :
               (bcond && taken) ? pc + disp :
               ((jcond && taken) || jal) ? jump_target : pc_inc;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
            pc <= RESET_PC;
            ir <= '0;
            psr <= '0;
        end else begin
            state <= state_n;
            pc <= pc_n;
            if (state == S_DECODE) ir <= bus.mem_rdata;
            if (exec && alu_cls && flag_op) psr <= bus.alu_flags;
        end
    end
endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: instruction-level reference model checking cpu_controller with directed and random programs
module tb_cpu_controller;
    localparam int ADDR_W = 16;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    cpu_controller_if #(.ADDR_W(ADDR_W)) bus();
    cpu_controller #(.ADDR_W(ADDR_W), .RESET_PC(16'h0000)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    logic [15:0] rf [16];
    logic [15:0] mem [65536];
    logic [15:0] m_rf [16];
    logic [15:0] m_mem [65536];
    logic [15:0] pc_m;
    logic [4:0] psr_m;
    logic [3:0] his [8] = '{4'h0, 4'h1, 4'h5, 4'h9, 4'hB, 4'hC, 4'h4, 4'h8};
    logic [3:0] los [4] = '{4'h0, 4'h4, 4'h8, 4'hC};
    int checks = 0;
    int errors = 0;
    // Stand-in ALU: add/sub for the arithmetic opcodes, a scramble for everything else
    function automatic logic [20:0] alu_model(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        logic sub, add;
        sub = op[7:4] inside {4'h9, 4'hB} || (op[7:4] == 4'h0 && op[3:0] inside {4'h9, 4'hB});
        add = op[7:4] == 4'h5 || op == 8'h05;
        r = sub ? a - b : add ? a + b : a ^ b ^ {op, op};
        return {a < b, a > b, r[15], r == 16'h0, $signed(a) < $signed(b), r};
    endfunction
    function automatic logic cond_ok(input logic [3:0] cc, input logic [4:0] p);
        logic c, l, f, z, n;
        {c, l, f, z, n} = p;
        case (cc)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return l;
            4'h5: return !l;
            4'h6: return n;
            4'h7: return !n;
            4'h8: return f;
            4'h9: return !f;
            4'hA: return !l && !z;
            4'hB: return l || z;
            4'hC: return !n && !z;
            4'hD: return n || z;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction
    assign bus.rf_rdata_a = rf[bus.rf_raddr_a];
    assign bus.rf_rdata_b = rf[bus.rf_raddr_b];
    assign {bus.alu_flags, bus.alu_c} = alu_model(bus.alu_op, bus.alu_a, bus.alu_b);
    always @(posedge clk) begin
        bus.mem_rdata <= mem[bus.mem_addr];
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.rf_we) rf[bus.rf_waddr] <= bus.rf_wdata;
    end
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic set_reg(input logic [3:0] r, input logic [15:0] v);
        rf[r] <= v;
        m_rf[r] = v;
    endtask
    task automatic set_mem(input logic [15:0] a, input logic [15:0] v);
        mem[a] <= v;
        m_mem[a] = v;
    endtask
    // Called at a falling edge with the controller in its fetch cycle; runs one whole instruction
    task automatic step(input logic [15:0] ins);
        logic [3:0] hi, lo, rd, rs;
        logic [15:0] a, b, r, opb, wd, npc, maddr;
        logic [4:0] fl;
        logic wr, st, ld;
        int lat, nrf, nmem;
        hi = ins[15:12];
        lo = ins[7:4];
        rd = ins[11:8];
        rs = ins[3:0];
        a = m_rf[rd];
        b = m_rf[rs];
        set_mem(pc_m, ins);
        lat = 3;
        npc = pc_m + 16'd1;
        wr = 1'b0;
        st = 1'b0;
        ld = 1'b0;
        wd = '0;
        maddr = '0;
        if (hi inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD, 4'hF} ||
            (hi == 4'h8 && lo inside {4'h0, 4'h1, 4'h4})) begin
            opb = (hi == 4'h0 || (hi == 4'h8 && lo == 4'h4)) ? b : hi == 4'h8 ? {12'h000, rs} : {8'h00, ins[7:0]};
            {fl, r} = alu_model({hi, lo}, a, opb);
            wr = !(hi == 4'hB || (hi == 4'h0 && lo == 4'hB));
            wd = r;
            if ((hi == 4'h0 ? lo : hi) inside {4'h1, 4'h5, 4'h9, 4'hB}) psr_m = fl;
        end else if (hi == 4'h4 && lo == 4'h0) begin
            ld = 1'b1;
            lat = 4;
            wr = 1'b1;
            maddr = b;
            wd = m_mem[b];
        end else if (hi == 4'h4 && lo == 4'h4) begin
            st = 1'b1;
            maddr = b;
            m_mem[b] = a;
        end else if (hi == 4'hC) begin
            if (cond_ok(rd, psr_m)) npc = pc_m + {{8{ins[7]}}, ins[7:0]};
        end else if (hi == 4'h4 && lo == 4'hC) begin
            if (cond_ok(rd, psr_m)) npc = b;
        end else if (hi == 4'h4 && lo == 4'h8) begin
            wr = 1'b1;
            wd = pc_m + 16'd1;
            npc = b;
        end
        nrf = 0;
        nmem = 0;
        for (int k = 0; k < lat; k++) begin
            if (k == 0) chk("fetch_addr", bus.mem_addr, pc_m);
            if (k < 2) chk("idle_we", {14'h0, bus.rf_we, bus.mem_we}, 16'h0);
            if (k == 2) begin
                chk("alu_op", {8'h00, bus.alu_op}, {8'h00, hi, lo});
                if (ld || st) chk("data_addr", bus.mem_addr, maddr);
                if (st) chk("store_data", bus.mem_wdata, a);
            end
            if (k == lat - 1 && wr) begin
                chk("wr_addr", {12'h000, bus.rf_waddr}, {12'h000, rd});
                chk("wr_data", bus.rf_wdata, wd);
            end
            chk("we_excl", {15'h0, bus.rf_we & bus.mem_we}, 16'h0);
            nrf += int'(bus.rf_we);
            nmem += int'(bus.mem_we);
            @(negedge clk);
        end
        chk("rf_we_count", 16'(nrf), {15'h0, wr});
        chk("mem_we_count", 16'(nmem), {15'h0, st});
        chk("pc", bus.pc_out, npc);
        chk("psr", {11'h0, bus.psr_out}, {11'h0, psr_m});
        if (wr) begin
            m_rf[rd] = wd;
            chk("rf", rf[rd], m_rf[rd]);
        end
        if (st) chk("mem", mem[maddr], m_mem[maddr]);
        pc_m = npc;
    endtask
    initial begin
        for (int i = 0; i < 65536; i++) set_mem(16'(i), 16'h0000);
        for (int i = 0; i < 16; i++) set_reg(4'(i), 16'($urandom));
        pc_m = '0;
        psr_m = '0;
        repeat (3) @(negedge clk);
        chk("reset_pc", bus.pc_out, 16'h0000);
        chk("reset_psr", {11'h0, bus.psr_out}, 16'h0000);
        chk("reset_we", {14'h0, bus.rf_we, bus.mem_we}, 16'h0);
        rst_n = 1'b1;
        set_reg(4'd1, 16'h0003);
        step(16'h5107);
        chk("addi_pc", bus.pc_out, 16'h0001);
        chk("addi_r1", rf[1], 16'h000A);
        set_reg(4'd2, 16'h0005);
        step(16'hB205);
        chk("cmpi_z", {15'h0, bus.psr_out[1]}, 16'h0001);
        step(16'hC004);
        chk("beq_taken", bus.pc_out, 16'h0006);
        set_reg(4'd2, 16'h0006);
        step(16'hB205);
        step(16'hC004);
        chk("beq_not_taken", bus.pc_out, 16'h0008);
        set_reg(4'd4, 16'h0020);
        set_mem(16'h0020, 16'hBEEF);
        step(16'h4304);
        chk("load_r3", rf[3], 16'hBEEF);
        set_reg(4'd5, 16'h1234);
        set_reg(4'd6, 16'h0040);
        step(16'h4546);
        chk("stor_mem", mem[16'h0040], 16'h1234);
        set_reg(4'd8, 16'h0010);
        step(16'h4EC8);
        set_reg(4'd7, 16'h0100);
        step(16'h4E87);
        chk("jal_link", rf[14], 16'h0011);
        chk("jal_pc", bus.pc_out, 16'h0100);
        step(16'h01B2);
        step(16'h0122);
        set_reg(4'd9, 16'hFFFF);
        step(16'h4EC9);
        step(16'h0152);
        chk("pc_wrap", bus.pc_out, 16'h0000);
        step(16'hCEFE);
        chk("branch_below_zero", bus.pc_out, 16'hFFFE);
        step(16'hCF05);
        chk("never_cond", bus.pc_out, 16'hFFFF);
        set_reg(4'd10, 16'h0300);
        step(16'h4A8A);
        chk("jal_same_reg_pc", bus.pc_out, 16'h0300);
        set_reg(4'd1, 16'h1111);
        set_reg(4'd2, 16'h2222);
        set_mem(pc_m, 16'h0152);
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_we", {15'h0, bus.rf_we}, 16'h0001);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_we", {14'h0, bus.rf_we, bus.mem_we}, 16'h0);
        chk("midreset_pc", bus.pc_out, 16'h0000);
        chk("midreset_psr", {11'h0, bus.psr_out}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        pc_m = '0;
        psr_m = '0;
        chk("midreset_no_write", rf[1], 16'h1111);
        set_reg(4'd1, 16'h0003);
        step(16'h5107);
        chk("resume_pc", bus.pc_out, 16'h0001);
        for (int i = 0; i < 300; i++) begin
            logic [15:0] ins;
            ins = 16'($urandom);
            if ($urandom_range(0, 9) < 7) begin
                ins[15:12] = his[$urandom_range(0, 7)];
                if (ins[15:12] == 4'h4) ins[7:4] = los[$urandom_range(0, 3)];
                else if (ins[15:12] == 4'h8) ins[7:4] = $urandom_range(0, 1) != 0 ? 4'h4 : 4'h0;
            end
            if ($urandom_range(0, 3) == 0) set_reg(4'($urandom), 16'($urandom));
            step(ins);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
